sub_i8v4_i8v4_i8v4: RTL and testbench
=====================================

Name: sub_i8v4_i8v4_i8v4

Overview:
- Four-lane SIMD subtractor on 8-bit two's-complement integers.
- Each output lane is y_i = a_i - b_i, i = 0..3.
- Leaf datapath primitive from the vector-op library; instantiated by generated/compiled netlists and by self-checking CI benches.
- Purely combinational: zero latency. The clock and reset ports exist for a uniform primitive interface only.

Parameters:
- None. Lane count is fixed at 4; lane width is fixed at 8.

Ports:
- clock  input  1  system clock; single clock domain; unused by the datapath.
- reset  input  1  synchronous, active-high reset; no effect on outputs.
- a_0  input  8  lane 0 minuend, signed two's complement.
- a_1  input  8  lane 1 minuend.
- a_2  input  8  lane 2 minuend.
- a_3  input  8  lane 3 minuend.
- b_0  input  8  lane 0 subtrahend, signed two's complement.
- b_1  input  8  lane 1 subtrahend.
- b_2  input  8  lane 2 subtrahend.
- b_3  input  8  lane 3 subtrahend.
- y_0  output  8  lane 0 difference, a_0 - b_0.
- y_1  output  8  lane 1 difference.
- y_2  output  8  lane 2 difference.
- y_3  output  8  lane 3 difference.

Interface note: one clock; reset is synchronous and active-high. Port names are clock and reset.

Behaviour:
- Arithmetic: y_i = (a_i - b_i) mod 256, per lane.
  - Computed as a_i + ~b_i + 1 and truncated to 8 bits.
  - No saturation. No carry, borrow or overflow outputs.
  - The bit pattern is identical for signed and unsigned interpretation.
- Lane independence: no carry or borrow propagates between lanes. Lane i depends only on a_i and b_i.
- Latency: 0 cycles. Outputs settle combinationally within the same cycle that inputs change.
  - A consumer sampling y at posedge N sees the inputs that were stable before posedge N.
- No registers, state machine or handshake. There are no valid or ready signals; every cycle is a valid operation.
- Reset: has no effect on the datapath.
  - Outputs track inputs continuously, including while reset is high.
  - There is no reset value distinct from the computed difference.
  - Asserting reset mid-operation does not alter y.
- Overflow wrap:
  - 0x80 - 0x01 = 0x7F (-128 - 1 wraps to +127).
  - 0x7F - 0xFF = 0x80 (127 - (-1) wraps to -128).
- Identity and edge cases:
  - a_i - 0 = a_i.
  - x - x = 0x00.
  - 0x00 - 0xFF = 0x01.
  - 0x00 - 0x80 = 0x80.
- No X propagation beyond normal combinational semantics. No latches are inferred.

Test Plan:
- Mixed-sign vector: a = [-4, 2, 2, 1], b = [1, 3, 0, 1], driven during reset. On the first cycle after reset deasserts, y = [-5, -1, 2, 0], i.e. [0xFB, 0xFF, 0x02, 0x00].
- Signed overflow wrap: a = [0x80, 0x7F, 0x00, 0x00], b = [0x01, 0xFF, 0xFF, 0x80] -> y = [0x7F, 0x80, 0x01, 0x80].
- Lane isolation: a = [0x00, 0xFF, 0x00, 0xFF], b = [0x01, 0x00, 0x01, 0x00] -> y = [0xFF, 0xFF, 0xFF, 0xFF]. No borrow leaks into adjacent lanes.
- Self-subtract and zero: a = b = [0x5A, 0xA5, 0x00, 0xFF] -> y = all 0x00. With b = 0, y = a.
- Reset independence: hold a = [10, 20, 30, 40], b = [1, 2, 3, 4] while toggling reset -> y stays [9, 18, 27, 36] in every cycle.
- Random regression: 1000 random cycles, each lane checked against a golden (a - b) & 0xFF in the same cycle.

Source files
------------

// File: rtl/sub_i8v4_i8v4_i8v4.sv
// Four-lane SIMD subtractor on 8-bit two's-complement integers.
// Purely combinational; clock and reset exist only for a uniform primitive interface.
module sub_i8v4_i8v4_i8v4 (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] a_0,
  input  logic [7:0] a_1,
  input  logic [7:0] a_2,
  input  logic [7:0] a_3,
  input  logic [7:0] b_0,
  input  logic [7:0] b_1,
  input  logic [7:0] b_2,
  input  logic [7:0] b_3,
  output logic [7:0] y_0,
  output logic [7:0] y_1,
  output logic [7:0] y_2,
  output logic [7:0] y_3
);

  localparam int Lanes = 4;

  logic [7:0] laneA [Lanes];
  logic [7:0] laneB [Lanes];
  logic [7:0] laneY [Lanes];

  assign laneA[0] = a_0;
  assign laneA[1] = a_1;
  assign laneA[2] = a_2;
  assign laneA[3] = a_3;
  assign laneB[0] = b_0;
  assign laneB[1] = b_1;
  assign laneB[2] = b_2;
  assign laneB[3] = b_3;

  // Each lane is its own 8-bit adder; the carry out of bit 7 is dropped so nothing crosses lanes.
  for (genvar i = 0; i < Lanes; i++) begin : gLane
    assign laneY[i] = laneA[i] + ~laneB[i] + 8'd1;
  end

  assign y_0 = laneY[0];
  assign y_1 = laneY[1];
  assign y_2 = laneY[2];
  assign y_3 = laneY[3];

  logic unusedSink;
  assign unusedSink = &{1'b0, clock, reset};

endmodule

// File: tb/tb_sub_i8v4_i8v4_i8v4.sv
// Directed and random checks for the four-lane 8-bit subtractor.
module tb_sub_i8v4_i8v4_i8v4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] aIn  [4];
  logic [7:0] bIn  [4];
  logic [7:0] yOut [4];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  sub_i8v4_i8v4_i8v4 dut (
    .clock (clock),
    .reset (reset),
    .a_0   (aIn[0]),
    .a_1   (aIn[1]),
    .a_2   (aIn[2]),
    .a_3   (aIn[3]),
    .b_0   (bIn[0]),
    .b_1   (bIn[1]),
    .b_2   (bIn[2]),
    .b_3   (bIn[3]),
    .y_0   (yOut[0]),
    .y_1   (yOut[1]),
    .y_2   (yOut[2]),
    .y_3   (yOut[3])
  );

  task automatic applyStimulus(input logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3);
    aIn[0] = a0; aIn[1] = a1; aIn[2] = a2; aIn[3] = a3;
    bIn[0] = b0; bIn[1] = b1; bIn[2] = b2; bIn[3] = b3;
  endtask

  task automatic test_reset();
    logic [7:0] expY [4];
    expY = '{8'hFB, 8'hFF, 8'h02, 8'h00};
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(8'hFC, 8'h02, 8'h02, 8'h01, 8'h01, 8'h03, 8'h00, 8'h01);
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (yOut[i] !== expY[i]) begin
        miscompares++;
        $display("[TB] FAIL reset_held lane %0d: got %h expected %h", i, yOut[i], expY[i]);
      end
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (yOut[i] !== expY[i]) begin
        miscompares++;
        $display("[TB] FAIL mixed_sign_after_reset lane %0d: got %h expected %h", i, yOut[i], expY[i]);
      end
    end
  endtask

  task automatic test_overflow_wrap();
    logic [7:0] expY [4];
    expY = '{8'h7F, 8'h80, 8'h01, 8'h80};
    @(negedge clock);
    applyStimulus(8'h80, 8'h7F, 8'h00, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'h80);
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (yOut[i] !== expY[i]) begin
        miscompares++;
        $display("[TB] FAIL overflow_wrap lane %0d: got %h expected %h", i, yOut[i], expY[i]);
      end
    end
  endtask

  task automatic test_lane_isolation();
    @(negedge clock);
    applyStimulus(8'h00, 8'hFF, 8'h00, 8'hFF, 8'h01, 8'h00, 8'h01, 8'h00);
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (yOut[i] !== 8'hFF) begin
        miscompares++;
        $display("[TB] FAIL lane_isolation lane %0d: got %h expected ff", i, yOut[i]);
      end
    end
  endtask

  task automatic test_self_subtract_and_zero();
    logic [7:0] expY [4];
    expY = '{8'h5A, 8'hA5, 8'h00, 8'hFF};
    @(negedge clock);
    applyStimulus(8'h5A, 8'hA5, 8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'hFF);
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (yOut[i] !== 8'h00) begin
        miscompares++;
        $display("[TB] FAIL self_subtract lane %0d: got %h expected 00", i, yOut[i]);
      end
    end
    @(negedge clock);
    applyStimulus(8'h5A, 8'hA5, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (yOut[i] !== expY[i]) begin
        miscompares++;
        $display("[TB] FAIL subtract_zero lane %0d: got %h expected %h", i, yOut[i], expY[i]);
      end
    end
  endtask

  task automatic test_reset_independence();
    logic [7:0] expY [4];
    expY = '{8'h09, 8'h12, 8'h1B, 8'h24};
    @(negedge clock);
    applyStimulus(8'd10, 8'd20, 8'd30, 8'd40, 8'd1, 8'd2, 8'd3, 8'd4);
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      reset = c[0];
      #1;
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (yOut[i] !== expY[i]) begin
          miscompares++;
          $display("[TB] FAIL reset_independence cycle %0d lane %0d: got %h expected %h",
                   c, i, yOut[i], expY[i]);
        end
      end
      @(posedge clock); #1;
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (yOut[i] !== expY[i]) begin
          miscompares++;
          $display("[TB] FAIL reset_independence_edge cycle %0d lane %0d: got %h expected %h",
                   c, i, yOut[i], expY[i]);
        end
      end
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] tabA [3][4];
    logic [7:0] tabB [3][4];
    logic [7:0] tabY [3][4];
    tabA = '{'{8'h10, 8'h20, 8'h30, 8'h40}, '{8'h01, 8'h80, 8'hFF, 8'h7F}, '{8'h33, 8'hC8, 8'h64, 8'h9C}};
    tabB = '{'{8'h01, 8'h02, 8'h03, 8'h04}, '{8'h02, 8'h7F, 8'h01, 8'h80}, '{8'h11, 8'h38, 8'h9C, 8'h64}};
    tabY = '{'{8'h0F, 8'h1E, 8'h2D, 8'h3C}, '{8'hFF, 8'h01, 8'hFE, 8'hFF}, '{8'h22, 8'h90, 8'hC8, 8'h38}};
    for (int v = 0; v < 3; v++) begin
      @(negedge clock);
      applyStimulus(tabA[v][0], tabA[v][1], tabA[v][2], tabA[v][3],
                    tabB[v][0], tabB[v][1], tabB[v][2], tabB[v][3]);
      @(posedge clock); #1;
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (yOut[i] !== tabY[v][i]) begin
          miscompares++;
          $display("[TB] FAIL back_to_back vec %0d lane %0d: got %h expected %h",
                   v, i, yOut[i], tabY[v][i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] expY [4];
    int         diff;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clock);
      reset = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < 4; i++) begin
        aIn[i] = 8'($urandom_range(0, 255));
        bIn[i] = 8'($urandom_range(0, 255));
        diff    = int'(aIn[i]) - int'(bIn[i]);
        if (diff < 0) diff = diff + 256;
        expY[i] = 8'(diff);
      end
      @(posedge clock); #1;
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (yOut[i] !== expY[i]) begin
          miscompares++;
          $display("[TB] FAIL random cycle %0d lane %0d: a=%h b=%h got %h expected %h",
                   c, i, aIn[i], bIn[i], yOut[i], expY[i]);
        end
      end
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    applyStimulus(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    test_reset();
    test_overflow_wrap();
    test_lane_isolation();
    test_self_subtract_and_zero();
    test_reset_independence();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
